// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. It takes a pixel strobe and
// produces the following outputs:
//   - sync levels
//   - blanking and active flags
//   - downscaled pixel coordinates
//   - line and frame event pulses
//
// The raster position can be frozen at runtime.
//
// All outputs are registered. They are decoded from the counters' *next*
// value, so every output reflects the current hcoun/vcoun with no extra
// latency.
//
// Optional build macro:
//   VGA_FRAME_CNT_EN - adds the 8-bit frame_cnt output. It increments on
//                      every advance that raises endscreen.
//
// Ports:
//   vgaclk      in   clock
//   inputreset  in   asynchronous active-low reset
//   pixelstb    in   pixel enable; the raster advances only when it is high
//   freeze      in   holds the raster (wins over pixelstb)
//   horizs      out  horizontal sync, HS_POL level while in sync
//   vertis      out  vertical sync, VS_POL level while in sync
//   blnk        out  high outside the active region
//   actv        out  ~blnk
//   ox          out  scaled active x, 0 in horizontal blanking
//   oy          out  scaled active y, holds last active row in vblank
//   linestart   out  pulse at the first active pixel of each active line
//   anm         out  pulse at the last pixel of the last active line
//   endscreen   out  pulse at the last pixel of the frame
//   frame_cnt   out  frame counter (VGA_FRAME_CNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int SCALE_LOG2 = 0,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  logic          vgaclk,
  input  logic          inputreset,
  input  logic          pixelstb,
  input  logic          freeze,
  output logic          horizs,
  output logic          vertis,
  output logic          blnk,
  output logic          actv,
  output logic [XW-1:0] ox,
  output logic [YW-1:0] oy,
  output logic          linestart,
  output logic          anm,
  output logic          endscreen
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Counter landmarks, pre-sized to the counter widths.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_FP + H_SYNC);
  localparam logic [HW-1:0] H_ACT_S  = HW'(H_BLANK);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // oy parks on the last active row through vblank, so the renderer keeps a
  // stable, in-range row index.
  localparam logic [VW-1:0] OY_PARK = VW'(V_ACT_L >> SCALE_LOG2);

  logic [HW-1:0] hcoun_reg, hcoun_next;
  logic [VW-1:0] vcoun_reg, vcoun_next;
  logic          adv;

  logic          hsync_next, vsync_next, hact_next, vact_next;
  logic [HW-1:0] hrel;
  logic [XW-1:0] ox_next;
  logic [YW-1:0] oy_next;
  logic          linestart_next, anm_next, endscreen_next;

  // Next raster position. freeze overrides the strobe.
  always_comb begin
    adv        = pixelstb & ~freeze;
    hcoun_next = hcoun_reg;
    vcoun_next = vcoun_reg;
    if (adv) begin
      if (hcoun_reg == H_LAST) begin
        hcoun_next = '0;
        vcoun_next = (vcoun_reg == V_LAST) ? '0 : vcoun_reg + VW'(1);
      end else begin
        hcoun_next = hcoun_reg + HW'(1);
      end
    end
  end

  // Decode from the next position so the registered outputs line up with
  // the counters on the same edge.
  always_comb begin
    hsync_next = (hcoun_next >= H_SYNC_S) && (hcoun_next < H_SYNC_E);
    vsync_next = (vcoun_next >= V_SYNC_S) && (vcoun_next < V_SYNC_E);
    hact_next  = (hcoun_next >= H_ACT_S);
    vact_next  = (vcoun_next < V_ACT_E);
    hrel       = hcoun_next - H_ACT_S;

    // ox depends on horizontal position only.
    ox_next = hact_next ? XW'(hrel >> SCALE_LOG2) : '0;
    oy_next = vact_next ? YW'(vcoun_next >> SCALE_LOG2) : YW'(OY_PARK);

    // Events fire only on an advancing cycle. A held position must not
    // re-trigger them.
    linestart_next = adv && (hcoun_next == H_ACT_S) && vact_next;
    anm_next       = adv && (vcoun_next == V_ACT_L) && (hcoun_next == H_LAST);
    endscreen_next = adv && (vcoun_next == V_LAST)  && (hcoun_next == H_LAST);
  end

  always_ff @(posedge vgaclk or negedge inputreset) begin
    if (!inputreset) begin
      hcoun_reg <= '0;
      vcoun_reg <= '0;
      horizs    <= ~HS_ON;
      vertis    <= ~VS_ON;
      blnk      <= 1'b1;
      actv      <= 1'b0;
      ox        <= '0;
      oy        <= '0;
      linestart <= 1'b0;
      anm       <= 1'b0;
      endscreen <= 1'b0;
    end else begin
      hcoun_reg <= hcoun_next;
      vcoun_reg <= vcoun_next;
      horizs    <= hsync_next ? HS_ON : ~HS_ON;
      vertis    <= vsync_next ? VS_ON : ~VS_ON;
      blnk      <= ~(hact_next & vact_next);
      actv      <= hact_next & vact_next;
      ox        <= ox_next;
      oy        <= oy_next;
      linestart <= linestart_next;
      anm       <= anm_next;
      endscreen <= endscreen_next;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Counts frames on the same advance that raises endscreen, wrapping mod 256.
  always_ff @(posedge vgaclk or negedge inputreset) begin
    if (!inputreset) begin
      frame_cnt <= '0;
    end else if (endscreen_next) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives two instances from shared inputs:
//   dut_a - default 640x480 timing
//   dut_b - tiny raster with active-high syncs and SCALE_LOG2=1
//
// A reference raster model pushes the expected outputs of every cycle into a
// queue per instance. The queue entry is popped and compared right after the
// clock edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  logic inputreset, pixelstb, freeze;

  logic       a_horizs, a_vertis, a_blnk, a_actv, a_linestart, a_anm, a_endscreen;
  logic [9:0] a_ox;
  logic [8:0] a_oy;
  logic       b_horizs, b_vertis, b_blnk, b_actv, b_linestart, b_anm, b_endscreen;
  logic [2:0] b_ox;
  logic [1:0] b_oy;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] a_fc, b_fc;
`endif

  vga_timing_gen dut_a (
    .vgaclk(vgaclk), .inputreset(inputreset), .pixelstb(pixelstb), .freeze(freeze),
    .horizs(a_horizs), .vertis(a_vertis), .blnk(a_blnk), .actv(a_actv),
    .ox(a_ox), .oy(a_oy), .linestart(a_linestart), .anm(a_anm), .endscreen(a_endscreen)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .SCALE_LOG2(1), .XW(3), .YW(2)
  ) dut_b (
    .vgaclk(vgaclk), .inputreset(inputreset), .pixelstb(pixelstb), .freeze(freeze),
    .horizs(b_horizs), .vertis(b_vertis), .blnk(b_blnk), .actv(b_actv),
    .ox(b_ox), .oy(b_oy), .linestart(b_linestart), .anm(b_anm), .endscreen(b_endscreen)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  typedef struct {
    int hfp, hsync, hbp, hact, vact, vfp, vsync, vbp, hspol, vspol, sc;
  } cfg_t;

  typedef struct {
    int h, v, hs, vs, bl, ac, ox, oy, ls, an, es, fc;
    bit ox_valid;
  } exp_t;

  cfg_t cfg [2];
  int   mh [2];
  int   mv [2];
  int   mfc [2];
  exp_t sb_a [$];
  exp_t sb_b [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_ls = -1, a_period = 0;
  int last_es = -1, b_period = 0;
  int es_count = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected outputs for instance k at the current model position.
  function automatic exp_t model_eval(input int k, input bit adv);
    exp_t e;
    cfg_t c = cfg[k];
    int h = mh[k];
    int v = mv[k];
    int hblank = c.hfp + c.hsync + c.hbp;
    int ht = hblank + c.hact;
    int vt = c.vact + c.vfp + c.vsync + c.vbp;
    e.h  = h;
    e.v  = v;
    e.hs = (h >= c.hfp && h < c.hfp + c.hsync) ? c.hspol : 1 - c.hspol;
    e.vs = (v >= c.vact + c.vfp && v < c.vact + c.vfp + c.vsync) ? c.vspol : 1 - c.vspol;
    e.ac = (h >= hblank && v < c.vact) ? 1 : 0;
    e.bl = 1 - e.ac;
    e.ox_valid = (h < hblank) || (v < c.vact);
    e.ox = (h >= hblank) ? ((h - hblank) >> c.sc) : 0;
    e.oy = (v < c.vact) ? (v >> c.sc) : ((c.vact - 1) >> c.sc);
    e.ls = (adv && h == hblank && v < c.vact) ? 1 : 0;
    e.an = (adv && v == c.vact - 1 && h == ht - 1) ? 1 : 0;
    e.es = (adv && v == vt - 1 && h == ht - 1) ? 1 : 0;
    e.fc = mfc[k];
    return e;
  endfunction

  task automatic model_advance(input bit adv);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int ht = cfg[k].hfp + cfg[k].hsync + cfg[k].hbp + cfg[k].hact;
      int vt = cfg[k].vact + cfg[k].vfp + cfg[k].vsync + cfg[k].vbp;
      if (adv) begin
        if (mh[k] == ht - 1) begin
          mh[k] = 0;
          mv[k] = (mv[k] == vt - 1) ? 0 : mv[k] + 1;
        end else begin
          mh[k] = mh[k] + 1;
        end
      end
      e = model_eval(k, adv);
      if (e.es != 0) begin
        mfc[k] = (mfc[k] + 1) % 256;
        e.fc = mfc[k];
      end
      if (k == 0) sb_a.push_back(e);
      else        sb_b.push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0;
      mv[k] = 0;
      mfc[k] = 0;
    end
  endtask

  task automatic check_dut(input string p, input exp_t e,
                           input logic [31:0] hs, input logic [31:0] vs,
                           input logic [31:0] bl, input logic [31:0] ac,
                           input logic [31:0] ox, input logic [31:0] oy,
                           input logic [31:0] ls, input logic [31:0] an,
                           input logic [31:0] es, input logic [31:0] fc);
    string at;
    at = $sformatf("@h%0d,v%0d", e.h, e.v);
    check_val({p, "_horizs", at}, hs, e.hs);
    check_val({p, "_vertis", at}, vs, e.vs);
    check_val({p, "_blnk", at}, bl, e.bl);
    check_val({p, "_actv", at}, ac, e.ac);
    if (e.ox_valid) check_val({p, "_ox", at}, ox, e.ox);
    check_val({p, "_oy", at}, oy, e.oy);
    check_val({p, "_linestart", at}, ls, e.ls);
    check_val({p, "_anm", at}, an, e.an);
    check_val({p, "_endscreen", at}, es, e.es);
`ifdef VGA_FRAME_CNT_EN
    check_val({p, "_frame_cnt", at}, fc, e.fc);
`else
    if (fc !== 32'd0) check_val({p, "_frame_cnt_absent", at}, fc, 32'd0);
`endif
  endtask

  task automatic compare_all();
    exp_t e;
    logic [31:0] afc, bfc;
`ifdef VGA_FRAME_CNT_EN
    afc = 32'(a_fc);
    bfc = 32'(b_fc);
`else
    afc = 32'd0;
    bfc = 32'd0;
`endif
    if (sb_a.size() == 0) begin
      check_val("sb_a_empty", 32'd0, 32'd1);
    end else begin
      e = sb_a.pop_front();
      check_dut("a", e, a_horizs, a_vertis, a_blnk, a_actv, 32'(a_ox), 32'(a_oy),
                a_linestart, a_anm, a_endscreen, afc);
    end
    if (sb_b.size() == 0) begin
      check_val("sb_b_empty", 32'd0, 32'd1);
    end else begin
      e = sb_b.pop_front();
      check_dut("b", e, b_horizs, b_vertis, b_blnk, b_actv, 32'(b_ox), 32'(b_oy),
                b_linestart, b_anm, b_endscreen, bfc);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then compare 1 ns later.
  task automatic step(input bit stb, input bit frz);
    pixelstb = stb;
    freeze   = frz;
    @(posedge vgaclk);
    model_advance(stb && !frz);
    #1;
    compare_all();
    cyc++;
    if (a_linestart === 1'b1) begin
      if (last_ls >= 0) a_period = cyc - last_ls;
      last_ls = cyc;
    end
    if (b_endscreen === 1'b1) begin
      if (last_es >= 0) b_period = cyc - last_es;
      last_es = cyc;
      es_count++;
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_a_horizs"}, a_horizs, 1);
    check_val({tag, "_a_vertis"}, a_vertis, 1);
    check_val({tag, "_a_blnk"}, a_blnk, 1);
    check_val({tag, "_a_actv"}, a_actv, 0);
    check_val({tag, "_a_ox"}, 32'(a_ox), 0);
    check_val({tag, "_a_oy"}, 32'(a_oy), 0);
    check_val({tag, "_a_pulses"}, {a_linestart, a_anm, a_endscreen}, 0);
    check_val({tag, "_b_horizs"}, b_horizs, 0);
    check_val({tag, "_b_vertis"}, b_vertis, 0);
    check_val({tag, "_b_blnk"}, b_blnk, 1);
    check_val({tag, "_b_actv"}, b_actv, 0);
    check_val({tag, "_b_ox"}, 32'(b_ox), 0);
    check_val({tag, "_b_oy"}, 32'(b_oy), 0);
    check_val({tag, "_b_pulses"}, {b_linestart, b_anm, b_endscreen}, 0);
`ifdef VGA_FRAME_CNT_EN
    check_val({tag, "_a_frame_cnt"}, 32'(a_fc), 0);
    check_val({tag, "_b_frame_cnt"}, 32'(b_fc), 0);
`endif
  endtask

  initial begin
    cfg[0] = '{16, 96, 48, 640, 480, 10, 2, 33, 0, 0, 0};
    cfg[1] = '{2, 2, 2, 8, 4, 1, 1, 1, 1, 1, 1};
    model_reset();
    inputreset = 1'b0;
    pixelstb   = 1'b0;
    freeze     = 1'b0;

    // Power-on reset, held across a few edges.
    #22;
    check_reset("por");
    inputreset = 1'b1;

    // No advance until the first strobe after release.
    repeat (3) step(1'b0, 1'b0);

    // Strobe every cycle: line period 800 (a), frame period 98 (b).
    last_ls = -1;
    last_es = -1;
    repeat (2400) step(1'b1, 1'b0);
    check_val("a_line_period_stb1", a_period, 800);
    check_val("b_frame_period_stb1", b_period, 98);

    // Strobe every 4th cycle: line period 3200 (a).
    last_ls = -1;
    a_period = 0;
    for (int i = 0; i < 7000; i++) step((i % 4) == 0, 1'b0);
    check_val("a_line_period_stb4", a_period, 3200);

    // Freeze at hcoun=500 with strobe active, then resume at 501.
    for (int i = 0; i < 1000 && mh[0] != 500; i++) step(1'b1, 1'b0);
    check_val("a_ox_at_freeze", 32'(a_ox), 340);
    for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)) | (i == 0), 1'b1);
    check_val("a_ox_during_freeze", 32'(a_ox), 340);
    step(1'b1, 1'b0);
    check_val("a_ox_after_freeze", 32'(a_ox), 341);

    // Random strobe/freeze mix.
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);

    // Asynchronous reset mid-line: outputs clear before the next edge.
    #2;
    inputreset = 1'b0;
    #1;
    check_reset("async");
    model_reset();
    pixelstb = 1'b1;
    @(posedge vgaclk);
    #1;
    check_reset("held");
    inputreset = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    repeat (120) step(1'b1, 1'b0);

`ifdef VGA_FRAME_CNT_EN
    // Frame counter wrap on dut_b after 256 endscreen pulses.
    es_count = 0;
    for (int i = 0; i < 30000 && es_count < 256; i++) begin
      step(1'b1, 1'b0);
      if (es_count == 255 && b_endscreen === 1'b1) check_val("b_fc_255", 32'(b_fc), 255);
    end
    check_val("b_es_count", es_count, 256);
    check_val("b_fc_wrap", 32'(b_fc), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
